// File: rtl/riscv_mmio_console.sv
// MMIO console for the single-cycle RISC-V data port: TX FIFO drained as 8N1 frames on tx.
// Define CONSOLE_EXIT_EN to enable the EXIT register (halt/exit_code); otherwise offset 0x8 is reserved.
module riscv_mmio_console #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        halt,
  output logic [31:0] exit_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wptr, r_rptr;
  logic            r_overflow;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit;
  logic [BW-1:0]   r_baud;

  logic [AW:0]     w_count;
  logic            w_full, w_empty, w_sel_tx, w_push, w_pop, w_baud_end, w_tx;
  logic [31:0]     w_status;
  logic            w_unused;

  assign hit        = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_count    = r_wptr - r_rptr;
  assign w_full     = (w_count == DEPTH);
  assign w_empty    = (w_count == '0);
  assign w_sel_tx   = hit & mem_write & (addr[3:2] == 2'd0);
  assign w_push     = w_sel_tx & ~w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_unused   = &{1'b0, addr[1:0], wdata[31:8]};

  assign w_status = {16'h0, 8'(w_count), 4'h0, r_overflow, (r_state != S_IDLE), w_empty, w_full};

  always_comb begin
    rdata = '0;
    if (hit && mem_read && addr[3:2] == 2'd1) rdata = w_status;
  end

  // Serializer: pop on entry to START, either from IDLE or straight out of the last STOP cycle
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_baud_end && r_bit == 3'd7) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx = w_tx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE || w_state_nxt != r_state || w_baud_end) r_baud <= '0;
      else r_baud <= r_baud + 1'b1;
      if (r_state != S_DATA) r_bit <= '0;
      else if (w_baud_end) r_bit <= r_bit + 3'd1;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_sel_tx) begin
        if (w_full) r_overflow <= 1'b1;
        else r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata[7:0];
    if (w_pop) r_shift <= r_mem[r_rptr[AW-1:0]];
    else if (r_state == S_DATA && w_baud_end) r_shift <= {1'b0, r_shift[7:1]};
  end

`ifdef CONSOLE_EXIT_EN
  logic        r_halt;
  logic [31:0] r_exit_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halt      <= 1'b0;
      r_exit_code <= '0;
    end else if (hit && mem_write && addr[3:2] == 2'd2) begin
      r_halt      <= 1'b1;
      r_exit_code <= wdata;
    end
  end

  assign halt      = r_halt;
  assign exit_code = r_exit_code;
`else
  assign halt      = 1'b0;
  assign exit_code = '0;
`endif

endmodule

// File: tb/tb_riscv_mmio_console.sv
// Scoreboard bench for riscv_mmio_console: a timing-level model predicts frames, a UART monitor checks them.
module tb_riscv_mmio_console;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int D = 8;
  localparam int C = 4;

  logic        clk, reset, mem_write, mem_read, hit, tx, halt;
  logic [31:0] addr, wdata, rdata, exit_code;

  riscv_mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .addr(addr), .wdata(wdata), .hit(hit), .rdata(rdata), .tx(tx),
    .halt(halt), .exit_code(exit_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        sb_q[$];
  logic [7:0]  m_fifo[$];
  int          m_busy = 0;
  logic        m_ovf = 1'b0;
  logic        m_halt = 1'b0;
  logic [31:0] m_exit = '0;
  int          m_cnt;
  logic [7:0]  m_b;
  logic        m_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [7:0] cnt;
    cnt = 8'(m_fifo.size());
    return {16'h0, cnt, 4'h0, m_ovf, (m_busy > 0), (cnt == 8'd0), (cnt == 8'(D))};
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    sb_q.delete();
    m_busy = 0;
    m_ovf  = 1'b0;
    m_halt = 1'b0;
    m_exit = '0;
  endtask

  // Reference model: a frame occupies the line for 10*C cycles; the next byte leaves as soon as it ends.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset) model_clear();
      else begin
        m_cnt = m_fifo.size();
        m_wr  = mem_write && (addr[31:4] == BASE[31:4]);
        if (m_cnt > 0 && m_busy <= 1) begin
          m_b = m_fifo.pop_front();
          sb_q.push_back('{m_b, cyc});
          m_busy = 10 * C;
        end else if (m_busy > 0) m_busy--;
        if (m_wr && addr[3:2] == 2'd0) begin
          if (m_cnt < D) m_fifo.push_back(wdata[7:0]);
          else m_ovf = 1'b1;
        end
`ifdef CONSOLE_EXIT_EN
        if (m_wr && addr[3:2] == 2'd2) begin
          m_halt = 1'b1;
          m_exit = wdata;
        end
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge reset);
      model_clear();
    end
  end

  // Monitor: decodes every frame on tx and compares it with the next scoreboard entry
  logic       mon_in_frame = 1'b0;
  logic       mon_have_exp;
  exp_t       mon_cur;
  int         mon_phase, mon_glitch, mon_bitpos;
  logic [7:0] mon_rx;
  logic       mon_expb;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) mon_in_frame = 1'b0;
      else begin
        if (!mon_in_frame && tx === 1'b0) begin
          mon_in_frame = 1'b1;
          mon_phase    = 0;
          mon_glitch   = 0;
          mon_rx       = '0;
          if (sb_q.size() == 0) begin
            mon_have_exp = 1'b0;
            checks++;
            failures++;
            $display("FAIL frame_unexpected: start bit at cycle %0d, none expected", cyc);
          end else begin
            mon_have_exp = 1'b1;
            mon_cur = sb_q.pop_front();
            chk("frame_start_cycle", 64'(cyc), 64'(mon_cur.start));
          end
        end
        if (mon_in_frame) begin
          mon_bitpos = mon_phase / C;
          if (mon_bitpos == 0) mon_expb = 1'b0;
          else if (mon_bitpos == 9) mon_expb = 1'b1;
          else mon_expb = mon_cur.data[mon_bitpos-1];
          if (mon_have_exp && tx !== mon_expb) mon_glitch++;
          if (mon_bitpos >= 1 && mon_bitpos <= 8 && (mon_phase % C) == C / 2)
            mon_rx[mon_bitpos-1] = tx;
          mon_phase++;
          if (mon_phase == 10 * C) begin
            mon_in_frame = 1'b0;
            if (mon_have_exp) begin
              chk("frame_data", 64'(mon_rx), 64'(mon_cur.data));
              chk("frame_line_errors", 64'(mon_glitch), 64'd0);
            end
          end
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; mem_write = 1'b1; mem_read = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; mem_read = 1'b1; mem_write = 1'b0;
    #1 chk(name, 64'(rdata), 64'(exp));
  endtask

  task automatic rd_status(input string name);
    @(negedge clk);
    addr = BASE + 32'h4; mem_read = 1'b1; mem_write = 1'b0;
    #1 chk(name, 64'(rdata), 64'(model_status()));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    mem_write = 1'b0;
    while ((sb_q.size() != 0 || m_fifo.size() != 0 || m_busy != 0 || mon_in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 3000), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0; addr = '0; wdata = '0;
    repeat (4) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_exit_code", 64'(exit_code), 64'd0);
    reset = 1'b1;
    rd("rst_status", BASE + 32'h4, 32'h0000_0002);

    // Single byte 0x41: tx falls one cycle after the write edge
    wr(BASE, 32'hFFFF_FF41);
    @(negedge clk);
    mem_write = 1'b0;
    chk("tx_high_after_push_edge", 64'(tx), 64'd1);
    @(negedge clk);
    chk("tx_falls_after_pop_edge", 64'(tx), 64'd0);
    rd_status("status_busy_41");
    wait_drain("drain_41");
    rd("status_idle_41", BASE + 32'h4, 32'h0000_0002);

    // 9 accepted, then 10 dropped while the FIFO is full
    for (int i = 0; i < 9; i++) wr(BASE, $urandom);
    rd_status("status_after_9");
    for (int i = 0; i < 10; i++) wr(BASE, $urandom);
    rd_status("status_after_overflow");
    chk("overflow_bit", 64'(rdata[3]), 64'd1);
    chk("full_bit", 64'(rdata[0]), 64'd1);
    wait_drain("drain_overflow");
    rd_status("status_drained_overflow");

    // Reset in the middle of the 0x5A frame with three bytes still queued
    wr(BASE, 32'h5A);
    for (int i = 0; i < 3; i++) wr(BASE, $urandom);
    idle(12);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("tx_high_in_reset", 64'(tx), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd("status_after_mid_reset", BASE + 32'h4, 32'h0000_0002);
    idle(120);
    chk("no_frames_after_reset", 64'(sb_q.size()), 64'd0);

    // Randomized bursts with gaps and interleaved status reads
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        wr(BASE + 32'(4 * $urandom_range(0, 0)), $urandom);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) rd_status("status_random");
      end
      wait_drain("drain_random");
      rd_status("status_random_drained");
    end

    // EXIT register
    wr(BASE + 32'h8, 32'h0000_0007);
    idle(1);
`ifdef CONSOLE_EXIT_EN
    chk("exit_halt", 64'(halt), 64'd1);
    chk("exit_code", 64'(exit_code), 64'd7);
    wr(BASE + 32'h8, 32'h0000_1234);
    idle(1);
    chk("exit_halt_sticky", 64'(halt), 64'd1);
    chk("exit_code_update", 64'(exit_code), 64'h1234);
`else
    chk("exit_disabled_halt", 64'(halt), 64'd0);
    chk("exit_disabled_code", 64'(exit_code), 64'd0);
`endif
    rd("exit_read_zero", BASE + 32'h8, 32'h0);

    // Outside the window and the reserved offset
    wr(BASE + 32'h10, 32'h55);
    #1 chk("hit_outside", 64'(hit), 64'd0);
    wr(BASE + 32'hC, 32'h66);
    #1 chk("hit_reserved", 64'(hit), 64'd1);
    rd("rdata_outside", BASE + 32'h10, 32'h0);
    #0 chk("hit_outside_read", 64'(hit), 64'd0);
    rd("rdata_reserved", BASE + 32'hC, 32'h0);
    rd("rdata_txdata_wo", BASE, 32'h0);
    rd("rdata_status_other_window", 32'h2000_0004, 32'h0);
    idle(2);
    rd_status("status_after_ignored_writes");
    chk("halt_after_ignored_writes", 64'(halt), 64'(m_halt));
    idle(60);
    chk("sb_empty_final", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_mmio_console.md
# riscv_mmio_console

Memory-mapped console transmitter on the data-memory port of `RISCV_Single_Cycle`. It reports from the core back to the environment.
- Stores to TXDATA enqueue bytes into a FIFO.
- A serializer drains the FIFO as 8N1 frames on `tx`.
- A write to EXIT raises `halt` with a code, so benches end on program completion rather than a fixed delay.
- The block sits beside data memory and claims only its own address window.

## Interface
- `BASE_ADDR`, 32'h1000_0000, base of the 16-byte register window (16-byte aligned).
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..64.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; at least 2.
- `clk` input 1: core clock.
- `reset` input 1: asynchronous, active-low reset.
- `mem_write` input 1: store strobe from the core.
- `mem_read` input 1: load strobe from the core.
- `addr` input 32: byte address.
- `wdata` input 32: store data.
- `hit` output 1: `addr` is inside the window; combinational.
- `rdata` output 32: load data; combinational.
- `tx` output 1: serial line, idle high.
- `halt` output 1: EXIT has been written (sticky).
- `exit_code` output 32: value written to EXIT.

## Operation
- Decode: `hit` = `addr[31:4] == BASE_ADDR[31:4]`. Offsets: 0x0 TXDATA (WO), 0x4 STATUS (RO), 0x8 EXIT (WO). Offset 0xC is reserved: reads 0, writes are ignored.
- TXDATA write (`hit & mem_write`): pushes `wdata[7:0]`; upper bits are ignored.
  - If the FIFO is full at that edge, the byte is dropped and sticky `overflow` is set.
  - The full test uses the pre-edge count. A simultaneous pop does not rescue the push.
- STATUS read, with `rdata` = 0 when `!(hit & mem_read)`:
  - bit0 full, bit1 empty, bit2 busy (serializer not IDLE), bit3 overflow.
  - bits[15:8] FIFO count, zero-extended. All other bits read 0.
- Reads of write-only offsets return 0. Reads and writes have no side effects outside the block.
- FIFO: circular buffer.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits; the wrap bit distinguishes full from empty.
  - count = wptr − rptr, modulo 2^(log2(FIFO_DEPTH)+1).
- Serializer FSM: IDLE → START → DATA → STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, 8 bits, each CLKS_PER_BIT cycles; a 3-bit bit index counts 0..7.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the last STOP cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT−1, reloads on every state change, and wraps to 0 at each bit boundary.
- Reset (asserted asynchronously at any time, including mid-frame):
  - FSM → IDLE, `tx`=1 immediately.
  - Pointers, count and overflow cleared; FIFO contents are discarded.
  - `halt`=0, `exit_code`=0, baud counter and bit index = 0.
- `hit` and `rdata` are combinational and follow the inputs.

## Timing
- A TXDATA write sampled at edge N makes the FIFO non-empty after edge N.
- The pop occurs at edge N+1, and `tx` falls after edge N+1 (one cycle of latency) when the serializer was IDLE.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back bytes produce contiguous frames.
- STATUS reflects register state after the most recent edge. No read latency: a same-cycle read suits the single-cycle core.
- Releasing `reset` does not depend on clock alignment; the first functional edge is the first rising `clk` with `reset`=1.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.

## Configuration
- `CONSOLE_EXIT_EN` defined:
  - An EXIT write at edge N sets `halt`=1 and `exit_code`=`wdata` after edge N.
  - A later EXIT write updates `exit_code`; `halt` stays 1 until reset.
  - TX draining continues while halted.
- Not defined:
  - Offset 0x8 behaves as reserved.
  - `halt` and `exit_code` are tied to 0 and no registers are generated for them.

## Test plan
- Reset with `reset`=0 for 4 cycles: `tx`=1, `halt`=0. STATUS read at BASE+4 returns 0x0000_0002.
- TXDATA write 0x41 with CLKS_PER_BIT=4: `tx` falls one cycle after the write edge. Then 4 cycles low and data bits 1,0,0,0,0,0,1,0 at 4 cycles each. Then 4 cycles high, and STATUS returns to 0x0000_0002.
- Write 9 bytes on consecutive cycles with FIFO_DEPTH=8:
  - The first pop happens one edge after the first push, so at most 8 bytes are ever pending and all 9 are accepted.
  - Then write 10 more bytes on consecutive cycles while the serializer is busy. The FIFO fills and the extra writes are dropped, setting STATUS bit3=1.
  - The transmitted frames contain exactly the accepted bytes, in order, with no gaps.
- Assert `reset` mid-DATA of byte 0x5A with 3 bytes queued: `tx`=1 immediately, FIFO empty after release, and no further frames appear.
- With `CONSOLE_EXIT_EN`, write 0x0000_0007 to BASE+8: `halt`=1 and `exit_code`=7 after that edge. Without the macro, `halt` stays 0.
- Access at BASE+0x10 (outside the window) and BASE+0xC (reserved): `hit`=0 at BASE+0x10, `rdata`=0 at both addresses, and neither write changes the FIFO or `halt`.
